// File: rtl/fetch_stage.sv
// F-stage fetch unit with IF/ID register: variable-latency req/ack instruction
// fetch, one-entry hold buffer for stalls, and PC/PC+4/PC+8 forwarding to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        fetch_stall,
   output logic [31:0] pc_F,
   output logic [31:0] IR_D,
   output logic [31:0] pc_D,
   output logic [31:0] pc4_D,
   output logic [31:0] pc8_D,
   output logic [31:0] fetch_cnt,
   output logic        misalign_err
);

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   state_t      state;
   logic [31:0] buffer;
   logic        done;
   logic        advance;
   logic [31:0] instr_F;

   assign imem_req    = (state == FETCH) & ~reset;
   assign imem_addr   = pc_F;
   assign done        = ((state == FETCH) & imem_ack) | (state == HOLD);
   assign instr_F     = (state == HOLD) ? buffer : imem_rdata;
   assign fetch_stall = (state == FETCH) & ~imem_ack;
   assign advance     = done & ~stall;

   // PC, IF/ID register and hold-buffer FSM; npc is only sampled on advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= FETCH;
         pc_F         <= RESET_PC;
         buffer       <= 32'd0;
         IR_D         <= 32'd0;
         pc_D         <= 32'd0;
         pc4_D        <= 32'd0;
         pc8_D        <= 32'd0;
         fetch_cnt    <= 32'd0;
         misalign_err <= 1'b0;
      end else if (advance) begin
         state     <= FETCH;
         IR_D      <= instr_F;
         pc_D      <= pc_F;
         pc4_D     <= pc_F + 32'd4;
         pc8_D     <= pc_F + 32'd8;
         pc_F      <= {npc[31:2], 2'b00};
         fetch_cnt <= fetch_cnt + 32'd1;
         if (npc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if ((state == FETCH) && imem_ack && stall) begin
         // word arrived during a stall: park it so the PC is never re-requested
         buffer <= imem_rdata;
         state  <= HOLD;
      end
   end

endmodule
